// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and data-memory signals of the load/store unit.
// The misaligned trap output exists only when LSU_MISALIGN_TRAP_EN is defined.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        mem_read;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;

  modport slave (
    input  req_valid, is_load, is_store, funct3, addr, store_data, mem_rdata,
    output req_ready, resp_valid, load_data, mem_read, mem_wr, mem_addr, mem_wdata, misaligned
  );
  modport master (
    output req_valid, is_load, is_store, funct3, addr, store_data, mem_rdata,
    input  req_ready, resp_valid, load_data, mem_read, mem_wr, mem_addr, mem_wdata, misaligned
  );
`else
  modport slave (
    input  req_valid, is_load, is_store, funct3, addr, store_data, mem_rdata,
    output req_ready, resp_valid, load_data, mem_read, mem_wr, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, is_load, is_store, funct3, addr, store_data, mem_rdata,
    input  req_ready, resp_valid, load_data, mem_read, mem_wr, mem_addr, mem_wdata
  );
`endif
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: word stores direct, byte/half stores via read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to trap unaligned half/word accesses instead of truncating.
module load_store_unit #(
  parameter int unsigned NUM_WORDS = 1024
) (
  input  logic             clk,
  input  logic             n_rst,
  load_store_unit_if.slave bus
);

  if (NUM_WORDS < 2) begin : g_depth_chk
    $error("load_store_unit: NUM_WORDS must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_MERGE} state_t;

  state_t      state_q, state_d;
  logic [29:0] widx_q, widx_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [15:0] sdat_q, sdat_d;

  logic        kind_ok, f3_legal, accept, mis;
  logic [1:0]  off_eff;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'b0, b};
      3'd5:    return {16'b0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic        is_half,
                                              input logic [15:0] sd);
    logic [31:0] m;
    m = word;
    if (is_half) begin
      if (off[1]) m[31:16] = sd;
      else        m[15:0]  = sd;
    end else begin
      m[{off, 3'b000} +: 8] = sd[7:0];
    end
    return m;
  endfunction

  assign kind_ok  = bus.is_load ^ bus.is_store;
  assign f3_legal = bus.is_load ? (bus.funct3 != 3'd3 && bus.funct3 != 3'd6 && bus.funct3 != 3'd7)
                                : (bus.funct3 <= 3'd2);
  assign accept   = bus.req_valid && (state_q == IDLE) && kind_ok && f3_legal;

  // Natural alignment of the byte offset; halfword keeps addr[1], word forces 0.
  always_comb begin
    case (bus.funct3[1:0])
      2'd1:    off_eff = {bus.addr[1], 1'b0};
      2'd2:    off_eff = 2'b00;
      default: off_eff = bus.addr[1:0];
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;

  assign mis = ((bus.funct3[1:0] == 2'd1) && bus.addr[0]) ||
               ((bus.funct3[1:0] == 2'd2) && (bus.addr[1:0] != 2'b00));
  assign misaligned_d   = accept && mis;
  assign bus.misaligned = misaligned_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) misaligned_q <= 1'b0;
    else        misaligned_q <= misaligned_d;
  end
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      widx_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      sdat_q  <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      sdat_q  <= sdat_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    widx_d         = widx_q;
    off_d          = off_q;
    f3_d           = f3_q;
    sdat_d         = sdat_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.load_data  = '0;
    bus.mem_read   = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept && !mis) begin
          widx_d       = bus.addr[31:2];
          off_d        = off_eff;
          f3_d         = bus.funct3;
          sdat_d       = bus.store_data[15:0];
          bus.mem_addr = {2'b00, bus.addr[31:2]};
          if (bus.is_load) begin
            bus.mem_read = 1'b1;
            state_d      = LOAD_WAIT;
          end else if (bus.funct3 == 3'd2) begin
            bus.mem_wr    = 1'b1;
            bus.mem_wdata = bus.store_data;
          end else begin
            bus.mem_read = 1'b1;
            state_d      = RMW_MERGE;
          end
        end
      end
      LOAD_WAIT: begin
        bus.resp_valid = 1'b1;
        bus.load_data  = load_extract(bus.mem_rdata, off_q, f3_q);
        state_d        = IDLE;
      end
      RMW_MERGE: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = {2'b00, widx_q};
        bus.mem_wdata = store_merge(bus.mem_rdata, off_q, f3_q[0], sdat_q);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle-latency word memory model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  load_store_unit_if bus();
  load_store_unit #(.NUM_WORDS(1024)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  logic [31:0] mem [0:1023];
  logic [31:0] rdata_q = '0;
  assign bus.mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (bus.mem_wr)   mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    if (bus.mem_read) rdata_q <= mem[bus.mem_addr[9:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.is_load    = ld;
    bus.is_store   = st;
    bus.funct3     = f3;
    bus.addr       = a;
    bus.store_data = d;
    #1;
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.is_load   = 1'b0;
    bus.is_store  = 1'b0;
    #1;
  endtask

  task automatic store_word(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, 3'd2, a, d);
    check("sw_wr", bus.mem_wr, 1'b1);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] exp, input string tag);
    drive(1'b1, 1'b0, f3, a, 32'h0);
    check({tag, "_rd"}, bus.mem_read, 1'b1);
    check({tag, "_idx"}, bus.mem_addr, {2'b00, a[31:2]});
    idle_cyc();
    check({tag, "_vld"}, bus.resp_valid, 1'b1);
    check(tag, bus.load_data, exp);
  endtask

  typedef struct { logic ld; logic [2:0] f3; logic [31:0] a; logic [31:0] d; } req_t;
  req_t        seq [3];
  int          acc_cyc [3];
  logic [31:0] resp [2];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    n_rst = 1'b0;
    bus.req_valid = 1'b0; bus.is_load = 1'b0; bus.is_store = 1'b0;
    bus.funct3 = 3'd0; bus.addr = '0; bus.store_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", bus.req_ready, 1'b1);
    check("rst_resp",  bus.resp_valid, 1'b0);
    check("rst_rd",    bus.mem_read, 1'b0);
    check("rst_wr",    bus.mem_wr, 1'b0);
    check("rst_ldata", bus.load_data, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;

    // SW then LW of the same word
    drive(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    check("sw_wr",    bus.mem_wr, 1'b1);
    check("sw_rd",    bus.mem_read, 1'b0);
    check("sw_idx",   bus.mem_addr, 32'd4);
    check("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
    load(3'd2, 32'h10, 32'hDEADBEEF, "lw10");
    idle_cyc();
    check("post_resp",  bus.resp_valid, 1'b0);
    check("post_ldata", bus.load_data, 32'h0);

    load(3'd0, 32'h13, 32'hFFFFFFDE, "lb13");
    load(3'd4, 32'h13, 32'h000000DE, "lbu13");
    load(3'd1, 32'h12, 32'hFFFFDEAD, "lh12");
    load(3'd5, 32'h10, 32'h0000BEEF, "lhu10");

    // Sub-word stores through read-modify-write
    store_word(32'h20, 32'h11223344);
    drive(1'b0, 1'b1, 3'd0, 32'h21, 32'h000000AA);
    check("sb_rd",    bus.mem_read, 1'b1);
    check("sb_wr0",   bus.mem_wr, 1'b0);
    idle_cyc();
    check("sb_ready", bus.req_ready, 1'b0);
    check("sb_wr",    bus.mem_wr, 1'b1);
    check("sb_rd1",   bus.mem_read, 1'b0);
    check("sb_idx",   bus.mem_addr, 32'd8);
    check("sb_wdata", bus.mem_wdata, 32'h1122AA44);
    check("sb_resp",  bus.resp_valid, 1'b0);
    idle_cyc();
    check("sb_ready2", bus.req_ready, 1'b1);
    store_word(32'h20, 32'h11223344);
    drive(1'b0, 1'b1, 3'd1, 32'h22, 32'hFFFF5566);
    idle_cyc();
    check("sh_wdata", bus.mem_wdata, 32'h55663344);
    load(3'd2, 32'h20, 32'h55663344, "lw20");

    // Rejected requests
    drive(1'b1, 1'b0, 3'd3, 32'h10, 32'h0);
    check("ill_ld_rd", bus.mem_read, 1'b0);
    idle_cyc();
    check("ill_ld_ready", bus.req_ready, 1'b1);
    check("ill_ld_resp",  bus.resp_valid, 1'b0);
    drive(1'b0, 1'b1, 3'd4, 32'h10, 32'h0);
    check("ill_st_rd", bus.mem_read, 1'b0);
    check("ill_st_wr", bus.mem_wr, 1'b0);
    drive(1'b1, 1'b1, 3'd2, 32'h10, 32'h0);
    check("both_rd", bus.mem_read, 1'b0);
    check("both_wr", bus.mem_wr, 1'b0);
    drive(1'b0, 1'b0, 3'd2, 32'h10, 32'h0);
    check("none_rd", bus.mem_read, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.is_load = 1'b1; #1;
    check("novld_rd", bus.mem_read, 1'b0);
    idle_cyc();
    check("novld_resp", bus.resp_valid, 1'b0);

    // Back-to-back LW, SB, LW with req_valid held
    seq[0] = '{1'b1, 3'd2, 32'h10, 32'h0};
    seq[1] = '{1'b0, 3'd0, 32'h24, 32'h00000077};
    seq[2] = '{1'b1, 3'd2, 32'h24, 32'h0};
    begin
      int idx = 0, nresp = 0, both = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
        @(negedge clk);
        if (idx < 3) begin
          bus.req_valid = 1'b1; bus.is_load = seq[idx].ld; bus.is_store = !seq[idx].ld;
          bus.funct3 = seq[idx].f3; bus.addr = seq[idx].a; bus.store_data = seq[idx].d;
        end else begin
          bus.req_valid = 1'b0; bus.is_load = 1'b0; bus.is_store = 1'b0;
        end
        #1;
        if (bus.mem_read && bus.mem_wr) both++;
        if (bus.resp_valid && nresp < 2) begin
          resp[nresp] = bus.load_data;
          nresp++;
        end
        if (idx < 3 && bus.req_ready) begin
          acc_cyc[idx] = cyc;
          idx++;
        end
        if (idx == 3 && nresp == 2) break;
      end
      check("b2b_accepted", idx, 3);
      check("b2b_nresp", nresp, 2);
      check("b2b_rd_wr_overlap", both, 0);
      check("b2b_acc0", acc_cyc[0], 0);
      check("b2b_acc1", acc_cyc[1], 2);
      check("b2b_acc2", acc_cyc[2], 4);
      check("b2b_resp0", resp[0], 32'hDEADBEEF);
      check("b2b_resp1", resp[1], 32'h00000077);
    end
    idle_cyc();

    // Reset during RMW_MERGE aborts the write
    store_word(32'h30, 32'hCAFEF00D);
    drive(1'b0, 1'b1, 3'd0, 32'h30, 32'h00000011);
    idle_cyc();
    n_rst = 1'b0;
    #1;
    check("rmw_rst_wr",    bus.mem_wr, 1'b0);
    check("rmw_rst_ready", bus.req_ready, 1'b1);
    @(negedge clk);
    n_rst = 1'b1;
    load(3'd2, 32'h30, 32'hCAFEF00D, "rmw_rst_word");

    // Reset during LOAD_WAIT suppresses the response
    drive(1'b1, 1'b0, 3'd2, 32'h30, 32'h0);
    idle_cyc();
    n_rst = 1'b0;
    #1;
    check("ldw_rst_resp",  bus.resp_valid, 1'b0);
    check("ldw_rst_ldata", bus.load_data, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    check("ldw_rst_after", bus.resp_valid, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
    drive(1'b1, 1'b0, 3'd2, 32'h11, 32'h0);
    check("mis_rd", bus.mem_read, 1'b0);
    check("mis_q0", bus.misaligned, 1'b0);
    idle_cyc();
    check("mis_pulse", bus.misaligned, 1'b1);
    check("mis_resp",  bus.resp_valid, 1'b0);
    idle_cyc();
    check("mis_clear", bus.misaligned, 1'b0);
    drive(1'b1, 1'b0, 3'd1, 32'h13, 32'h0);
    check("mis_h_rd", bus.mem_read, 1'b0);
    idle_cyc();
    check("mis_h_pulse", bus.misaligned, 1'b1);
`else
    load(3'd2, 32'h11, 32'hDEADBEEF, "lw11_trunc");
    load(3'd1, 32'h13, 32'hFFFFDEAD, "lh13_trunc");
`endif
    idle_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
